// File: rtl/counter_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// counter_ctrl_pkg
// Shared types and constants for the counter run controller.
//   state_t   : controller states (IDLE, RUN, HOLD)
//   WRAPS_W   : width of the completed-period counter
//   WRAPS_MAX : saturation value of the completed-period counter
// -----------------------------------------------------------------------------
package counter_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2
   } state_t;

   localparam int                 WRAPS_W   = 8;
   localparam logic [WRAPS_W-1:0] WRAPS_MAX = 8'd255;

endpackage

// File: rtl/counter_ctrl_prescaler.sv
// -----------------------------------------------------------------------------
// counter_ctrl_prescaler
// Divides advance edges by PRESCALE. Produces a one-cycle tick on the advance
// edge that completes each group of PRESCALE advance edges.
//   clk  : system clock, rising edge
//   rst  : asynchronous active-low reset
//   en   : advance edge qualifier (prescaler counts only when high)
//   clr  : synchronous clear, wins over en
//   tick : high when en is high and the prescaler is at PRESCALE-1
// -----------------------------------------------------------------------------
module counter_ctrl_prescaler #(
   parameter int PRESCALE = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic tick
);

   generate
      if (PRESCALE <= 1) begin : g_bypass
         // Every advance edge is a tick; no state is needed.
         logic unused_ok;
         assign unused_ok = ^{clk, rst, clr};
         assign tick      = en;
      end else begin : g_count
         localparam int            PW   = $clog2(PRESCALE);
         localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

         logic [PW-1:0] cnt;

         assign tick = en && (cnt == LAST);

         // NOTE: sequential state uses non-blocking assignments so every flop
         // samples the pre-edge values, independent of process ordering.
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               cnt <= '0;
            end else if (clr) begin
               cnt <= '0;
            end else if (en) begin
               cnt <= tick ? '0 : cnt + 1'b1;
            end
         end
      end
   endgenerate

endmodule

// File: rtl/counter_ctrl.sv
// -----------------------------------------------------------------------------
// counter_ctrl
// Run controller for the up-counter datapath: one-shot or periodic runs up to
// a latched terminal value, stepped through a prescaler, with pause and abort.
//   clk      : system clock, rising edge
//   rst      : asynchronous active-low reset
//   start    : begin a run (sampled in IDLE only)
//   periodic : run mode latched with start (1 = auto-restart)
//   limit    : terminal count latched with start
//   pause    : level; freezes count and prescaler while high
//   abort    : return to IDLE and clear count, prescaler and wraps
//   busy     : high in RUN or HOLD
//   paused   : high in HOLD
//   count    : current count value
//   done     : one-cycle pulse after the terminal tick
//   wraps    : completed periods since start, saturating
// -----------------------------------------------------------------------------
module counter_ctrl
   import counter_ctrl_pkg::*;
#(
   parameter int WIDTH    = 4,
   parameter int PRESCALE = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               periodic,
   input  logic [WIDTH-1:0]   limit,
   input  logic               pause,
   input  logic               abort,
   output logic               busy,
   output logic               paused,
   output logic [WIDTH-1:0]   count,
   output logic               done,
   output logic [WRAPS_W-1:0] wraps
);

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   limit_q;
   logic               periodic_q;
   logic [WIDTH-1:0]   count_d;
   logic [WRAPS_W-1:0] wraps_d;
   logic               done_d;
   logic               latch_en;
   logic               adv;
   logic               tick;
   logic               presc_clr;
   logic               terminal;

   // An advance edge: running, and neither abort nor pause is sampled high.
   // Leaving HOLD with pause low is therefore also an advance edge.
   assign adv       = (state_q != IDLE) && !abort && !pause;
   assign presc_clr = abort || ((state_q == IDLE) && start);
   assign terminal  = (count == limit_q);

   counter_ctrl_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .clk  (clk),
      .rst  (rst),
      .en   (adv),
      .clr  (presc_clr),
      .tick (tick)
   );

   // NOTE: every signal driven here gets a default first, so no path through
   // the block leaves a value unassigned and no latch is inferred.
   always_comb begin
      state_d  = state_q;
      count_d  = count;
      wraps_d  = wraps;
      done_d   = 1'b0;
      latch_en = 1'b0;

      if (abort) begin
         state_d = IDLE;
         count_d = '0;
         wraps_d = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  state_d  = RUN;
                  latch_en = 1'b1;
                  count_d  = '0;
                  wraps_d  = '0;
               end
            end
            RUN, HOLD: begin
               if (pause) begin
                  state_d = HOLD;
               end else begin
                  state_d = RUN;
                  if (tick) begin
                     if (terminal) begin
                        done_d = 1'b1;
                        if (wraps != WRAPS_MAX) wraps_d = wraps + 1'b1;
                        // One-shot leaves count at limit; periodic restarts.
                        if (periodic_q) count_d = '0;
                        else            state_d = IDLE;
                     end else begin
                        count_d = count + 1'b1;
                     end
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // busy/paused are registered from the next state so they track the state
   // flops exactly without any decode logic on the output path.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         busy       <= 1'b0;
         paused     <= 1'b0;
         count      <= '0;
         wraps      <= '0;
         done       <= 1'b0;
         limit_q    <= '0;
         periodic_q <= 1'b0;
      end else begin
         state_q <= state_d;
         busy    <= (state_d != IDLE);
         paused  <= (state_d == HOLD);
         count   <= count_d;
         wraps   <= wraps_d;
         done    <= done_d;
         if (latch_en) begin
            limit_q    <= limit;
            periodic_q <= periodic;
         end
      end
   end

endmodule

// File: tb/tb_counter_ctrl.sv
// -----------------------------------------------------------------------------
// tb_counter_ctrl
// Drives two controller instances (PRESCALE=1 and PRESCALE=2) from shared
// inputs and compares them against a reference model that tracks advance
// edges within the current period and derives count arithmetically.
// -----------------------------------------------------------------------------
module tb_counter_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic       periodic = 1'b0;
   logic [3:0] limit = 4'd0;
   logic       pause = 1'b0;
   logic       abort = 1'b0;

   logic       busy1, paused1, done1;
   logic [3:0] count1;
   logic [7:0] wraps1;
   logic       busy2, paused2, done2;
   logic [3:0] count2;
   logic [7:0] wraps2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   counter_ctrl #(.WIDTH(4), .PRESCALE(1)) dut1 (
      .clk(clk), .rst(rst), .start(start), .periodic(periodic), .limit(limit),
      .pause(pause), .abort(abort), .busy(busy1), .paused(paused1),
      .count(count1), .done(done1), .wraps(wraps1)
   );

   counter_ctrl #(.WIDTH(4), .PRESCALE(2)) dut2 (
      .clk(clk), .rst(rst), .start(start), .periodic(periodic), .limit(limit),
      .pause(pause), .abort(abort), .busy(busy2), .paused(paused2),
      .count(count2), .done(done2), .wraps(wraps2)
   );

   // Reference model state: adv counts advance edges inside the current period.
   typedef struct packed {
      logic busy;
      logic paused;
      logic per;
      logic done;
      int   lim;
      int   adv;
      int   count;
      int   wraps;
   } model_t;

   model_t m1, m2;

   function automatic model_t model_step(model_t m, int p, bit s, bit per,
                                         int lim, bit pa, bit ab);
      m.done = 1'b0;
      if (ab) begin
         m.busy = 1'b0; m.paused = 1'b0;
         m.count = 0; m.wraps = 0; m.adv = 0;
      end else if (!m.busy) begin
         if (s) begin
            m.busy = 1'b1; m.paused = 1'b0; m.per = per; m.lim = lim;
            m.count = 0; m.wraps = 0; m.adv = 0;
         end
      end else if (pa) begin
         m.paused = 1'b1;
      end else begin
         m.paused = 1'b0;
         m.adv    = m.adv + 1;
         if (m.adv == (m.lim + 1) * p) begin
            m.done = 1'b1;
            m.adv  = 0;
            if (m.wraps < 255) m.wraps = m.wraps + 1;
            if (m.per) m.count = 0;
            else       m.busy  = 1'b0;
         end else begin
            m.count = m.adv / p;
         end
      end
      return m;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic compare_all();
      check("busy1",   32'(busy1),   32'(m1.busy));
      check("paused1", 32'(paused1), 32'(m1.paused));
      check("done1",   32'(done1),   32'(m1.done));
      check("count1",  32'(count1),  32'(m1.count));
      check("wraps1",  32'(wraps1),  32'(m1.wraps));
      check("busy2",   32'(busy2),   32'(m2.busy));
      check("paused2", 32'(paused2), 32'(m2.paused));
      check("done2",   32'(done2),   32'(m2.done));
      check("count2",  32'(count2),  32'(m2.count));
      check("wraps2",  32'(wraps2),  32'(m2.wraps));
   endtask

   // One clock edge: drive on the falling edge, step the model at the rising
   // edge, compare 1 time unit later.
   task automatic cycle(input bit s, input bit per, input int lim,
                        input bit pa, input bit ab);
      @(negedge clk);
      start = s; periodic = per; limit = lim[3:0]; pause = pa; abort = ab;
      @(posedge clk);
      m1 = model_step(m1, 1, s, per, lim, pa, ab);
      m2 = model_step(m2, 2, s, per, lim, pa, ab);
      #1;
      compare_all();
   endtask

   task automatic idle(input int n);
      repeat (n) cycle(1'b0, 1'b0, 0, 1'b0, 1'b0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      m1 = '0;
      m2 = '0;

      // Reset state
      #1;
      compare_all();
      @(negedge clk);
      rst = 1'b1;

      // One-shot, limit=3
      cycle(1'b1, 1'b0, 3, 1'b0, 1'b0);
      check("os_busy_start", 32'(busy1), 32'd1);
      check("os_count0", 32'(count1), 32'd0);
      for (int i = 1; i <= 3; i++) begin
         idle(1);
         check("os_count_step", 32'(count1), 32'(i));
      end
      idle(1);
      check("os_done", 32'(done1), 32'd1);
      check("os_busy_end", 32'(busy1), 32'd0);
      idle(1);
      check("os_done_once", 32'(done1), 32'd0);
      check("os_count_hold", 32'(count1), 32'd3);
      idle(6);

      // Periodic, limit=2, nine edges
      cycle(1'b1, 1'b1, 2, 1'b0, 1'b0);
      idle(9);
      check("per_wraps", 32'(wraps1), 32'd3);
      check("per_count", 32'(count1), 32'd0);
      check("per_busy", 32'(busy1), 32'd1);
      cycle(1'b0, 1'b0, 0, 1'b0, 1'b1);

      // limit=0 periodic: saturation of wraps
      cycle(1'b1, 1'b1, 0, 1'b0, 1'b0);
      idle(600);
      check("sat_wraps2", 32'(wraps2), 32'd255);
      check("sat_wraps1", 32'(wraps1), 32'd255);
      check("sat_count2", 32'(count2), 32'd0);
      cycle(1'b0, 1'b0, 0, 1'b0, 1'b1);

      // Pause for 4 cycles at count=2, limit=5 one-shot
      cycle(1'b1, 1'b0, 5, 1'b0, 1'b0);
      idle(2);
      check("pause_pre", 32'(count1), 32'd2);
      repeat (4) begin
         cycle(1'b0, 1'b0, 0, 1'b1, 1'b0);
         check("pause_hold_count", 32'(count1), 32'd2);
         check("pause_paused", 32'(paused1), 32'd1);
      end
      idle(1);
      check("pause_resume", 32'(count1), 32'd3);
      check("pause_unpaused", 32'(paused1), 32'd0);
      idle(2);
      check("pause_no_early_done", 32'(done1), 32'd0);
      idle(1);
      check("pause_late_done", 32'(done1), 32'd1);
      idle(20);

      // Abort on the terminal edge, then abort with start in IDLE
      cycle(1'b1, 1'b0, 2, 1'b0, 1'b0);
      idle(2);
      check("ab_pre", 32'(count1), 32'd2);
      cycle(1'b0, 1'b0, 0, 1'b0, 1'b1);
      check("ab_count", 32'(count1), 32'd0);
      check("ab_busy", 32'(busy1), 32'd0);
      check("ab_done", 32'(done1), 32'd0);
      idle(1);
      check("ab_done_after", 32'(done1), 32'd0);
      cycle(1'b1, 1'b0, 3, 1'b0, 1'b1);
      check("ab_start_busy1", 32'(busy1), 32'd0);
      check("ab_start_busy2", 32'(busy2), 32'd0);

      // Asynchronous reset mid-run
      cycle(1'b1, 1'b1, 7, 1'b0, 1'b0);
      idle(3);
      @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      check("rst_busy", 32'(busy1), 32'd0);
      check("rst_count", 32'(count1), 32'd0);
      check("rst_paused", 32'(paused1), 32'd0);
      check("rst_done", 32'(done1), 32'd0);
      check("rst_wraps", 32'(wraps1), 32'd0);
      check("rst_busy2", 32'(busy2), 32'd0);
      check("rst_count2", 32'(count2), 32'd0);
      m1 = '0;
      m2 = '0;
      @(negedge clk);
      rst = 1'b1;

      // Fresh run after reset; start while busy must be ignored
      cycle(1'b1, 1'b0, 4, 1'b0, 1'b0);
      check("fresh_busy", 32'(busy1), 32'd1);
      cycle(1'b1, 1'b1, 9, 1'b0, 1'b0);
      idle(3);
      check("ign_count", 32'(count1), 32'd4);
      idle(1);
      check("ign_done", 32'(done1), 32'd1);
      check("ign_busy", 32'(busy1), 32'd0);
      idle(12);

      // Randomized stimulus
      repeat (400) begin
         cycle($urandom_range(0, 99) < 30, 1'($urandom_range(0, 1)),
               int'($urandom_range(0, 15)), $urandom_range(0, 99) < 20,
               $urandom_range(0, 99) < 4);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/counter_ctrl.md
# counter_ctrl

Run controller for the team's up-counter datapath. It accepts a start command with a programmable terminal value and runs the counter in one-shot or periodic mode through an internal prescaler. It supports pause and abort, and reports completion with a one-cycle `done` pulse. It sits between control logic (or a testbench) and the plain `counter` datapath, sequencing when the counter advances and when it clears.

## Interface
Parameters:
- `WIDTH`, 4: width of the count and limit (matches the 4-bit `counter`).
- `PRESCALE`, 1: clock cycles per count step; legal values are ≥1.

Ports (clock and reset first):
- `clk`  in  1  single system clock; everything is on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a run. Sampled only in IDLE.
- `periodic`  in  1  mode, latched with `start`. 1 = auto-restart, 0 = one-shot.
- `limit`  in  WIDTH  terminal count, latched with `start`.
- `pause`  in  1  level. While high in RUN/HOLD, the count and prescaler freeze.
- `abort`  in  1  return to IDLE from any state and clear all counters.
- `busy`  out  1  high in RUN or HOLD.
- `paused`  out  1  high in HOLD.
- `count`  out  WIDTH  current count value.
- `done`  out  1  one-cycle pulse on terminal count.
- `wraps`  out  8  completed periods since start, saturating at 255.

## Operation
- States: IDLE, RUN, HOLD.
- Reset (rst=0) forces IDLE immediately and asynchronously. `busy`, `paused`, `done` = 0; `count`, `wraps` and prescaler = 0; latched `limit` and `periodic` = 0.
- IDLE:
  - With `start`=1 and `abort`=0 at an edge: latch `limit` and `periodic`, clear `count`, prescaler and `wraps`, then go to RUN.
  - `count` otherwise holds its last value. After a one-shot run it shows `limit`.
- Advance edge: state is RUN or HOLD, `abort`=0 and `pause`=0.
  - The prescaler increments on every advance edge.
  - When the prescaler equals PRESCALE−1, it is a tick: the prescaler goes to 0.
- Tick with `count`≠limit: `count`+1.
- Tick with `count`==limit (terminal): `done`=1 for the next cycle, and `wraps`+1 (saturating at 255).
  - periodic=1: `count` goes to 0 and the block stays running.
  - periodic=0: `count` holds `limit` and the state goes to IDLE.
- RUN/HOLD transitions:
  - RUN with `pause`=1 goes to HOLD.
  - HOLD with `pause`=0 goes to RUN. That same edge is an advance edge.
- Priority at each edge: abort > pause > tick.
- abort: go to IDLE, `count`, prescaler and `wraps` = 0, and `done` is suppressed even on a terminal tick.
- `start` is ignored in RUN and HOLD; the latched `limit` and `periodic` are unaffected.
- `limit` = 0 is legal: every tick is terminal.
- All arithmetic is unsigned modulo width. `count` never exceeds the latched `limit`.

## Timing
- `start` sampled at edge N: `busy`=1 from N. The first count step is at edge N+PRESCALE.
- Run length: one period is (limit+1)×PRESCALE advance edges. `done` is high during the cycle after the terminal edge.
- One-shot: `busy` falls on the same edge that raises `done`.
- A new `start` is accepted at the earliest on the edge after `busy` falls.
- `pause` and `abort` act on the edge where they are sampled high (zero latency).
- All outputs are registered. There are no combinational input-to-output paths.

## Structure
- Package `counter_ctrl_pkg` holds:
  - the state enum (IDLE/RUN/HOLD);
  - the `WRAPS_W`=8 constant;
  - the `WRAPS_MAX` constant.
- One sub-module, `counter_ctrl_prescaler`, parameterised by PRESCALE:
  - inputs `en` and `clr`;
  - output `tick`;
  - for PRESCALE=1, `tick`=`en`.
- The FSM, the count register and the wraps register stay in `counter_ctrl`.

## Test plan
- One-shot, PRESCALE=1, limit=3, start pulse at edge N:
  - `count` reads 1, 2, 3 at edges N+1 to N+3;
  - `done` pulses after edge N+4;
  - `busy`=0 and `count`=3 remain afterwards.
- Periodic, PRESCALE=1, limit=2, run 9 edges:
  - `count` sequence 0,1,2,0,1,2,0,1,2,0;
  - `done` pulses after edges 3, 6 and 9;
  - `wraps` reads 3.
- PRESCALE=2, limit=0, periodic:
  - `done` every 2 cycles;
  - `count` stays 0;
  - over 600 cycles `wraps` saturates at 255.
- Pause: limit=5, PRESCALE=1, `pause` high for 4 cycles at `count`=2:
  - `count` holds 2 and `paused`=1 throughout;
  - resumes to 3 on the edge `pause` falls;
  - `done` is delayed by exactly 4 cycles.
- Abort at the terminal edge (count==limit): no `done`, `count`=0, `busy`=0. Abort and start in the same cycle in IDLE: the block stays IDLE.
- `rst` asserted mid-run, asynchronously between edges: all outputs go to 0 immediately. After release, a `start` behaves like a fresh run, and `start` during `busy` is ignored.
